quad_pos_counter: RTL
=====================

Name: quad_pos_counter

Overview:
- Parametrised successor to the two-input up/down position counter in the AC-motor path.
- Decodes a 2-bit quadrature phase pair (in2, in3) into a saturating signed-free position count bounded by [MIN_VAL, MAX_VAL].
- Adds input synchronisation, x4/x1 decode modes, direction, illegal-step detection, synchronous preload and saturation flags.
- Feeds the speed/availability logic downstream.

Parameters:
- WIDTH, 3, count width in bits.
- MIN_VAL, 0, lower saturation bound (unsigned, < MAX_VAL).
- MAX_VAL, 5, upper saturation bound (unsigned, <= 2^WIDTH-1).
- X1_MODE, 0: 0 counts every legal phase edge (x4); 1 counts only the 10<->00 edge (x1).

Ports:
- orgclk  in  1  system clock; all logic on rising edge, no derived clocks.
- rst  in  1  synchronous, active-high reset.
- in2  in  1  phase A, asynchronous.
- in3  in  1  phase B, asynchronous.
- en  in  1  count enable; when low, the phase is still tracked but count holds.
- load  in  1  preload strobe.
- load_val  in  WIDTH  preload value.
- err_clr  in  1  clears err_flag.
- count  out  WIDTH  current position.
- max  out  WIDTH  constant MAX_VAL.
- available  out  1  high when count < MAX_VAL.
- at_min  out  1  high when count == MIN_VAL.
- dir  out  1  last legal direction: 1 = up, 0 = down.
- step_err  out  1  one-cycle pulse on illegal transition.
- err_flag  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst=1 at an orgclk edge):
  - count=MIN_VAL, dir=1, step_err=0, err_flag=0, available=1, at_min=1.
  - Sync flops cleared; init flag set.
- Input path:
  - in2 and in3 each pass through a 2-flop synchroniser.
  - The phase is ph={in3_s,in2_s}, and prev_ph is a register of ph.
  - First cycle after reset: prev_ph<=ph, no count and no error (init flag cleared).
- Up sequence is 00->01->11->10->00; down is the reverse.
- Transition decode per cycle (ph vs prev_ph):
  - Equal: no step.
  - One bit differs and matches the up sequence: up step.
  - One bit differs and matches the down sequence: down step.
  - Both bits differ: illegal. step_err=1 for that cycle, err_flag<=1, count and dir unchanged.
- X1_MODE=1: only the 10->00 edge (up) and the 00->10 edge (down) produce steps. Other legal edges update prev_ph only. Illegal detection is unchanged.
- On any up/down step, dir updates regardless of en or saturation.
- Count update priority, highest first:
  1. rst
  2. load: count<=clamp(load_val, MIN_VAL, MAX_VAL). This discards any same-cycle step; dir still updates.
  3. en && up: count<=count+1, saturating at MAX_VAL.
  4. en && down: count<=count-1, saturating at MIN_VAL. No wrap-around in either direction.
- Arithmetic is done in WIDTH+1 bits so that no compare overflows.
- available and at_min are registered, consistent with count in the same cycle.
- Latency: a pin edge reaches count on the 3rd rising orgclk edge (2 sync + 1 update).
- err_clr clears err_flag; a simultaneous new illegal step wins, leaving err_flag=1.
- rst mid-sequence: discards the in-flight phase and re-initialises per the first-cycle rule.

Optional Feature:
- Macro QUAD_FILTER_EN.
  - Defined: each synchronised phase bit passes through a 3-sample majority-stable filter. The output changes only after 3 consecutive equal samples, which adds 2 cycles of latency (total 5). Filter registers reset to 0.
  - Undefined: no filter, latency 3, no extra registers.

Test Plan:
- Reset, then drive {in3,in2} 00->01->11->10->00 holding each phase 4 cycles, defaults -> count 0,1,2,3,4; dir=1; available=1; each update 3 cycles after its edge.
- From count=4, continue up 3 more edges -> count=5 then held at 5; available=0 from the first cycle count=5; dir=1.
- From count=5, walk the down sequence 6 edges -> count 4,3,2,1,0,0; at_min=1 at 0; dir=0.
- Jump phase 00->11 -> step_err pulses exactly 1 cycle, err_flag=1, count unchanged. Then err_clr=1 for 1 cycle -> err_flag=0.
- load=1, load_val=7 at the same cycle as an up step -> count=5 (clamped), dir=1. Then en=0 with 2 up edges -> count stays 5.
- X1_MODE=1, a full up cycle of 4 edges -> count +1 only, on the 10->00 edge.

Source files
------------

// File: rtl/quad_pos_counter.sv
// rtl/quad_pos_counter.sv - quadrature phase decoder with saturating position count
// Optional QUAD_FILTER_EN adds a 3-sample stability filter per synchronised phase bit.
module quad_pos_counter #(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 5,
  parameter int X1_MODE = 0
) (
  input  logic             orgclk,
  input  logic             rst,
  input  logic             in2,
  input  logic             in3,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] max,
  output logic             available,
  output logic             at_min,
  output logic             dir,
  output logic             step_err,
  output logic             err_flag
);

  localparam logic [WIDTH:0] MIN_W = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

  logic [1:0]       sync_m_q, sync_m_d, sync_s_q, sync_s_d;
  logic [1:0]       prev_ph_q, prev_ph_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_err_q, step_err_d;
  logic             err_flag_q, err_flag_d;
  logic             avail_q, avail_d;
  logic             at_min_q, at_min_d;
  logic [1:0]       ph;

  function automatic logic [1:0] next_up(input logic [1:0] p);
    case (p)
      2'b00:   next_up = 2'b01;
      2'b01:   next_up = 2'b11;
      2'b11:   next_up = 2'b10;
      default: next_up = 2'b00;
    endcase
  endfunction

`ifdef QUAD_FILTER_EN
  logic [1:0] hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;

  // A bit only moves once the current and two previous samples agree.
  always_comb begin
    hist1_d = sync_s_q;
    hist2_d = hist1_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = (sync_s_q[i] == hist1_q[i] && hist1_q[i] == hist2_q[i]) ?
                  sync_s_q[i] : filt_q[i];
    end
    ph = filt_d;
  end

  always_ff @(posedge orgclk) begin
    if (rst) begin
      hist1_q <= 2'b00;
      hist2_q <= 2'b00;
      filt_q  <= 2'b00;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      filt_q  <= filt_d;
    end
  end
`else
  assign ph = sync_s_q;
`endif

  logic           up_edge, down_edge, illegal, up_step, down_step;
  logic [WIDTH:0] cnt_w, cur_w, load_w;

  always_comb begin
    sync_m_d   = {in3, in2};
    sync_s_d   = sync_m_q;
    prev_ph_d  = ph;
    init_d     = 1'b0;
    dir_d      = dir_q;
    step_err_d = 1'b0;
    err_flag_d = err_flag_q;

    up_edge   = (ph == next_up(prev_ph_q));
    down_edge = (prev_ph_q == next_up(ph));
    illegal   = !init_q && (ph == ~prev_ph_q);
    if (X1_MODE != 0) begin
      up_step   = !init_q && up_edge && (prev_ph_q == 2'b10);
      down_step = !init_q && down_edge && (prev_ph_q == 2'b00);
    end else begin
      up_step   = !init_q && up_edge;
      down_step = !init_q && down_edge;
    end

    if (up_step)   dir_d = 1'b1;
    if (down_step) dir_d = 1'b0;

    if (err_clr) err_flag_d = 1'b0;
    if (illegal) begin
      step_err_d = 1'b1;
      err_flag_d = 1'b1;
    end

    // One spare bit keeps the +1/-1 compares free of overflow.
    cur_w  = {1'b0, count_q};
    load_w = {1'b0, load_val};
    cnt_w  = cur_w;
    if (load) begin
      if (load_w > MAX_W)      cnt_w = MAX_W;
      else if (load_w < MIN_W) cnt_w = MIN_W;
      else                     cnt_w = load_w;
    end else if (en && up_step) begin
      cnt_w = (cur_w >= MAX_W) ? MAX_W : cur_w + 1'b1;
    end else if (en && down_step) begin
      cnt_w = (cur_w <= MIN_W) ? MIN_W : cur_w - 1'b1;
    end
    count_d  = cnt_w[WIDTH-1:0];
    avail_d  = (cnt_w < MAX_W);
    at_min_d = (cnt_w == MIN_W);
  end

  always_ff @(posedge orgclk) begin
    if (rst) begin
      sync_m_q   <= 2'b00;
      sync_s_q   <= 2'b00;
      prev_ph_q  <= 2'b00;
      init_q     <= 1'b1;
      count_q    <= MIN_W[WIDTH-1:0];
      dir_q      <= 1'b1;
      step_err_q <= 1'b0;
      err_flag_q <= 1'b0;
      avail_q    <= (MIN_W < MAX_W);
      at_min_q   <= 1'b1;
    end else begin
      sync_m_q   <= sync_m_d;
      sync_s_q   <= sync_s_d;
      prev_ph_q  <= prev_ph_d;
      init_q     <= init_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      step_err_q <= step_err_d;
      err_flag_q <= err_flag_d;
      avail_q    <= avail_d;
      at_min_q   <= at_min_d;
    end
  end

  assign count     = count_q;
  assign max       = MAX_W[WIDTH-1:0];
  assign available = avail_q;
  assign at_min    = at_min_q;
  assign dir       = dir_q;
  assign step_err  = step_err_q;
  assign err_flag  = err_flag_q;

endmodule
